// File: rtl/mips8_controller.sv
// Multicycle Moore control unit for the 8-bit MIPS datapath: fetch/decode/execute FSM,
// ALU decoder and PC-enable logic. Define CTRL_ADDI_EN to add the ADDI instruction.
module mips8_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       regwrite,
  output logic [3:0] irwrite,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int unsigned CTRL_W = 19;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,  FETCH2  = 4'd1,  FETCH3  = 4'd2,  FETCH4 = 4'd3,
    DECODE  = 4'd4,  MEMADR  = 4'd5,  LBRD    = 4'd6,  LBWR   = 4'd7,
    SBWR    = 4'd8,  RTYPEEX = 4'd9,  RTYPEWR = 4'd10, BEQEX  = 4'd11,
    JEX     = 4'd12, ADDIWR  = 4'd13
  } state_t;

  state_t            state_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              memwrite_q;
  logic              regwrite_q;
  logic [3:0]        irwrite_q;
  logic [1:0]        aluop;
  logic              pcwrite;
  logic              branch;

  // Next-state function; op is only consulted in DECODE and MEMADR.
  function automatic state_t next_state(input state_t s, input logic [5:0] opc);
    state_t n;
    n = FETCH1;
    case (s)
      FETCH1:  n = FETCH2;
      FETCH2:  n = FETCH3;
      FETCH3:  n = FETCH4;
      FETCH4:  n = DECODE;
      DECODE: begin
        case (opc)
          OP_LB, OP_SB: n = MEMADR;
          OP_RTYPE:     n = RTYPEEX;
          OP_BEQ:       n = BEQEX;
          OP_J:         n = JEX;
`ifdef CTRL_ADDI_EN
          OP_ADDI:      n = MEMADR;
`else
          OP_ADDI:      n = FETCH1;
`endif
          default:      n = FETCH1;
        endcase
      end
      MEMADR: begin
        case (opc)
          OP_LB:   n = LBRD;
          OP_SB:   n = SBWR;
`ifdef CTRL_ADDI_EN
          OP_ADDI: n = ADDIWR;
`endif
          default: n = FETCH1;
        endcase
      end
      LBRD:    n = LBWR;
      RTYPEEX: n = RTYPEWR;
      default: n = FETCH1;
    endcase
    return n;
  endfunction

  // Moore output decode for one state, packed for registering alongside the state.
  function automatic logic [CTRL_W-1:0] ctrl_of(input state_t s);
    logic       mr, mw, asa, mtr, rd, io, rw, pw, br;
    logic [1:0] asb, ps, ao;
    logic [3:0] irw;
    mr = 1'b0; mw = 1'b0; asa = 1'b0; mtr = 1'b0; rd = 1'b0; io = 1'b0;
    rw = 1'b0; pw = 1'b0; br = 1'b0; asb = 2'b00; ps = 2'b00; ao = 2'b00;
    irw = 4'b0000;
    case (s)
      FETCH1:  begin mr = 1'b1; irw = 4'b0001; asb = 2'b01; pw = 1'b1; end
      FETCH2:  begin mr = 1'b1; irw = 4'b0010; asb = 2'b01; pw = 1'b1; end
      FETCH3:  begin mr = 1'b1; irw = 4'b0100; asb = 2'b01; pw = 1'b1; end
      FETCH4:  begin mr = 1'b1; irw = 4'b1000; asb = 2'b01; pw = 1'b1; end
      DECODE:  asb = 2'b11;
      MEMADR:  begin asa = 1'b1; asb = 2'b10; end
      LBRD:    begin mr = 1'b1; io = 1'b1; end
      LBWR:    begin rw = 1'b1; mtr = 1'b1; end
      SBWR:    begin mw = 1'b1; io = 1'b1; end
      RTYPEEX: begin asa = 1'b1; ao = 2'b10; end
      RTYPEWR: begin rw = 1'b1; rd = 1'b1; end
      BEQEX:   begin asa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
      JEX:     begin ps = 2'b10; pw = 1'b1; end
      ADDIWR:  rw = 1'b1;
      default: ;
    endcase
    return {mr, mw, asa, asb, mtr, rd, io, ps, rw, irw, ao, pw, br};
  endfunction

  // State and its decoded outputs are registered together from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH1;
      ctrl_q  <= ctrl_of(FETCH1);
    end else begin
      state_q <= next_state(state_q, op);
      ctrl_q  <= ctrl_of(next_state(state_q, op));
    end
  end

  assign {memread, memwrite_q, alusrca, alusrcb, memtoreg, regdst, iord,
          pcsrc, regwrite_q, irwrite_q, aluop, pcwrite, branch} = ctrl_q;

  // Write strobes are suppressed for the whole reset cycle.
  assign memwrite = memwrite_q & ~reset;
  assign regwrite = regwrite_q & ~reset;
  assign irwrite  = reset ? 4'b0000 : irwrite_q;
  assign pcen     = ~reset & (pcwrite | (branch & zero));
  assign state    = state_q;

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: doc/mips8_controller.md
Name: mips8_controller

Overview:
- Multicycle control unit for the 8-bit MIPS datapath `datav`; sits directly upstream and drives every datapath control input.
- Moore FSM sequences byte-wise instruction fetch (4 cycles), decode, execute, memory and writeback.
- Includes ALU decoder (aluop + funct -> alucontrol) and PC-enable logic (pcwrite | branch & zero).

Parameters:
- OP_LB, 6'b100000, load-byte opcode
- OP_SB, 6'b101000, store-byte opcode
- OP_RTYPE, 6'b000000, R-type opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode (used only with CTRL_ADDI_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from datapath IR
- funct  in  6  instr[5:0] from datapath IR
- zero  in  1  ALU zero flag from datapath
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- alusrca  out  1  0 = PC, 1 = A register
- alusrcb  out  2  00 = B register, 01 = const 1, 10 = imm8, 11 = imm<<2
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = MDR
- regdst  out  1  destination register: 0 = rt, 1 = rd
- iord  out  1  address: 0 = PC, 1 = ALUOut
- pcen  out  1  PC load enable
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- regwrite  out  1  register file write enable
- irwrite  out  4  one-hot IR byte write enable
- alucontrol  out  3  ALU operation
- state  out  4  current state, for debug/bench

Behaviour:
- State encoding:
  - FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5
  - LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIWR=13
  - Codes 14 and 15 are illegal and go to FETCH1 on the next edge.
- Reset: state <= FETCH1 on the clk edge while reset is high.
  - While reset is high, memwrite, regwrite, pcen and irwrite are forced to 0, independent of state.
  - All other outputs decode from state.
- Outputs are pure Moore functions of state, except pcen, which also depends on zero.
  - Default for every state: all outputs 0, aluop = 00.
- Per-state outputs:
  - FETCHn (n = 1..4): memread=1, irwrite=1<<(n-1), alusrca=0, alusrcb=01, aluop=00, pcsrc=00, pcwrite=1.
  - DECODE: alusrcb=11, aluop=00. Computes the branch target into ALUOut.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1, regdst=0.
  - SBWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - RTYPEWR: regwrite=1, regdst=1, memtoreg=0.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - JEX: pcsrc=10, pcwrite=1.
  - ADDIWR: regwrite=1, regdst=0, memtoreg=0.
- PC enable: pcen = pcwrite | (branch & zero), evaluated in the same cycle as zero (combinational).
- Transitions:
  - FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE, unconditional.
  - DECODE: LB or SB -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; J -> JEX; any other opcode -> FETCH1 (executes as a no-op, 5 cycles total).
  - MEMADR: LB -> LBRD; SB -> SBWR; anything else -> FETCH1.
  - LBRD -> LBWR; RTYPEEX -> RTYPEWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR -> FETCH1.
- Instruction latencies (cycles, fetch included):
  - LB 8; SB 7; R-type 7; BEQ 6; J 6; ADDI 7.
- ALU decoder:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; other funct -> 010.
  - aluop 11 -> 010.
- op and funct are sampled only in DECODE, MEMADR and RTYPEEX; the IR holds them stable after FETCH4.
- Reset mid-instruction: the FSM abandons the instruction and returns to FETCH1; no write strobe is asserted during the reset cycle.

Optional Feature:
- Macro CTRL_ADDI_EN.
- Defined: DECODE sends OP_ADDI -> MEMADR, and MEMADR sends OP_ADDI -> ADDIWR, which writes A+imm to rt.
- Undefined: OP_ADDI is an unknown opcode (DECODE -> FETCH1), and state ADDIWR is never entered.

Test Plan:
- Reset held 2 cycles, then released -> state=0; the next 4 cycles show irwrite = 0001, 0010, 0100, 1000 with pcen=1 and alusrcb=01 each cycle; cycle 5 has state=4, pcen=0.
- op=0x20 (LB) -> states 0,1,2,3,4,5,6,7,0. LBRD has iord=1, memread=1; LBWR has regwrite=1, memtoreg=1. No memwrite at any point.
- op=0, funct=0x22 (sub) -> RTYPEEX shows alucontrol=110; RTYPEWR shows regdst=1, regwrite=1.
- op=0x04 (BEQ):
  - zero=1 -> BEQEX has pcen=1, pcsrc=01, alucontrol=110.
  - zero=0 -> pcen=0; next state is FETCH1 in both cases.
- op=0x02 (J) -> JEX has pcen=1, pcsrc=10; op=0x3F -> DECODE -> FETCH1 with no write strobes asserted.
- op=0x08 with CTRL_ADDI_EN -> MEMADR then ADDIWR with regwrite=1. Without the macro -> DECODE -> FETCH1.
- reset asserted during SBWR -> memwrite=0 in that cycle; state=0 on the next edge.
